mtimer: RTL and testbench

- Memory-mapped machine timer that generates the `timer_interrupt` level consumed by `csr_reg`.
- It sits on the data-memory bus beside `data_mem`. It shares the same `rd_en`/`wr_en`/`addr`/`wdata`/`rdata` signalling and is selected by address decode.
- It holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp`, a programmable prescaler and a control register.
- It drives `timer_interrupt` when `mtime >= mtimecmp` and the interrupt is enabled.

---
 rtl/mtimer_pkg.sv | 20 ++
 rtl/mtimer_presc.sv | 44 ++++
 rtl/mtimer.sv | 144 ++++++++++++++
 tb/tb_mtimer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared constants for the memory-mapped machine timer: register offsets,
// CTRL field positions and reset values.
package mtimer_pkg;

    localparam logic [7:0] OFF_MTIME_LO      = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI      = 8'h04;
    localparam logic [7:0] OFF_MTIMECMP_LO   = 8'h08;
    localparam logic [7:0] OFF_MTIMECMP_HI   = 8'h0C;
    localparam logic [7:0] OFF_CTRL          = 8'h10;
    localparam logic [7:0] OFF_STATUS        = 8'h14;
    localparam logic [7:0] OFF_MTIME_HI_SNAP = 8'h18;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_DIV_LSB = 8;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] CTRL_RST     = 32'h0000_0001;

endpackage

// File: rtl/mtimer_presc.sv
// Prescaler for the machine timer: counts 0..div while enabled and flags a
// tick in the cycle the count equals div.
module mtimer_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick = en && (cnt_q == div);

    // next count: a CTRL write restarts the period, disable freezes it
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == div) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaler, control and
// a registered interrupt level; LO reads snapshot the upper half of mtime.
module mtimer
    import mtimer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        timer_interrupt
);

    logic [63:0]        mtime_q,    mtime_d;
    logic [63:0]        mtimecmp_q, mtimecmp_d;
    logic               en_q,       en_d;
    logic               irq_en_q,   irq_en_d;
    logic [PRESC_W-1:0] div_q,      div_d;
    logic [31:0]        hi_shadow_q, hi_shadow_d;
    logic               irq_q,      irq_d;

    logic [7:0]  off_s;
    logic        sel_s;
    logic        wr_s;
    logic        rd_s;
    logic        ctrl_wr_s;
    logic        tick_s;
    logic        cmp_ge_s;
    logic [31:0] ctrl_rd_s;

    assign off_s     = addr[7:0];
    assign hit       = (addr[31:8] == BASE_ADDR[31:8]);
    assign sel_s     = hit && (addr[1:0] == 2'b00);
    assign wr_s      = wr_en && sel_s;
    assign rd_s      = rd_en && sel_s;
    assign ctrl_wr_s = wr_s && (off_s == OFF_CTRL);
    assign cmp_ge_s  = (mtime_q >= mtimecmp_q);
    assign timer_interrupt = irq_q;

    mtimer_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en_q),
        .div  (div_q),
        .clr  (ctrl_wr_s),
        .tick (tick_s)
    );

    // register-file next state; a write to either mtime half swallows the tick
    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        div_d       = div_q;
        hi_shadow_d = hi_shadow_q;
        if (wr_s && (off_s == OFF_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], wdata};
        end else if (wr_s && (off_s == OFF_MTIME_HI)) begin
            mtime_d = {wdata, mtime_q[31:0]};
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
        if (wr_s && (off_s == OFF_MTIMECMP_LO)) begin
            mtimecmp_d = {mtimecmp_q[63:32], wdata};
        end else if (wr_s && (off_s == OFF_MTIMECMP_HI)) begin
            mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        if (ctrl_wr_s) begin
            en_d     = wdata[CTRL_EN];
            irq_en_d = wdata[CTRL_IRQ_EN];
            div_d    = wdata[CTRL_DIV_LSB +: PRESC_W];
        end else begin
            en_d     = en_q;
            irq_en_d = irq_en_q;
            div_d    = div_q;
        end
        if (rd_s && (off_s == OFF_MTIME_LO)) begin
            hi_shadow_d = mtime_q[63:32];
        end else begin
            hi_shadow_d = hi_shadow_q;
        end
        irq_d = irq_en_q && cmp_ge_s;
    end

    // CTRL readback with unused bits forced to zero
    always_comb begin
        ctrl_rd_s                               = 32'h0000_0000;
        ctrl_rd_s[CTRL_EN]                      = en_q;
        ctrl_rd_s[CTRL_IRQ_EN]                  = irq_en_q;
        ctrl_rd_s[CTRL_DIV_LSB +: PRESC_W]      = div_q;
    end

    // combinational read mux, zero outside the window or without a read strobe
    always_comb begin
        rdata = 32'h0000_0000;
        if (rd_s) begin
            case (off_s)
                OFF_MTIME_LO:      rdata = mtime_q[31:0];
                OFF_MTIME_HI:      rdata = mtime_q[63:32];
                OFF_MTIMECMP_LO:   rdata = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI:   rdata = mtimecmp_q[63:32];
                OFF_CTRL:          rdata = ctrl_rd_s;
                OFF_STATUS:        rdata = {31'd0, cmp_ge_s};
                OFF_MTIME_HI_SNAP: rdata = hi_shadow_q;
                default:           rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= MTIMECMP_RST;
            en_q        <= CTRL_RST[CTRL_EN];
            irq_en_q    <= CTRL_RST[CTRL_IRQ_EN];
            div_q       <= CTRL_RST[CTRL_DIV_LSB +: PRESC_W];
            hi_shadow_q <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            div_q       <= div_d;
            hi_shadow_q <= hi_shadow_d;
            irq_q       <= irq_d;
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// Directed self-checking bench for mtimer: reset values, prescaling, carry,
// snapshot, interrupt latency, write-wins-over-tick, decode and mid-run reset.
module tb_mtimer;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        hit;
    logic        timer_interrupt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] d;
    logic        h;

    always #10 clk = ~clk;

    mtimer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .wdata           (wdata),
        .rdata           (rdata),
        .hit             (hit),
        .timer_interrupt (timer_interrupt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr_raw(input logic [31:0] a, input logic [31:0] v);
        addr  = a;
        wdata = v;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] v);
        wr_raw(BASE | {24'd0, off}, v);
    endtask

    task automatic peek_raw(input logic [31:0] a, output logic [31:0] v, output logic hv);
        addr  = a;
        rd_en = 1'b1;
        #1;
        v     = rdata;
        hv    = hit;
        rd_en = 1'b0;
        addr  = 32'd0;
    endtask

    task automatic peek(input logic [7:0] off, output logic [31:0] v);
        logic hv;
        peek_raw(BASE | {24'd0, off}, v, hv);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] v);
        addr  = BASE | {24'd0, off};
        rd_en = 1'b1;
        #1;
        v = rdata;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        addr  = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        peek(8'h00, d); check("rst_mtime_lo", d, 32'h0000_0000);
        peek(8'h08, d); check("rst_cmp_lo", d, 32'hFFFF_FFFF);
        peek(8'h0C, d); check("rst_cmp_hi", d, 32'hFFFF_FFFF);
        peek(8'h14, d); check("rst_status", d, 32'h0000_0000);
        idle(5);
        peek(8'h00, d); check("run5_lo", d, 32'h0000_0005);
        peek(8'h04, d); check("run5_hi", d, 32'h0000_0000);
        check("run5_irq", {31'd0, timer_interrupt}, 32'd0);
        peek(8'h10, d); check("run5_ctrl", d, 32'h0000_0001);

        // div=3: one increment every 4 cycles
        wr(8'h10, 32'h0000_0303);
        wr(8'h00, 32'h0000_0000);
        idle(12);
        peek(8'h00, d); check("div3_lo", d, 32'h0000_0003);
        peek(8'h10, d); check("div3_ctrl", d, 32'h0000_0303);
        check("div3_irq", {31'd0, timer_interrupt}, 32'd0);

        // LO carry into HI and coherent snapshot
        wr(8'h10, 32'h0000_0001);
        wr(8'h04, 32'h0000_0000);
        wr(8'h00, 32'hFFFF_FFFE);
        idle(3);
        rd(8'h00, d); check("carry_lo", d, 32'h0000_0001);
        rd(8'h18, d); check("carry_snap", d, 32'h0000_0001);
        peek(8'h04, d); check("carry_hi", d, 32'h0000_0001);

        // full 64-bit wrap
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h00, 32'hFFFF_FFFF);
        idle(1);
        peek(8'h00, d); check("wrap_lo", d, 32'h0000_0000);
        peek(8'h04, d); check("wrap_hi", d, 32'h0000_0000);

        // interrupt latency and deassertion
        wr(8'h10, 32'h0000_0000);
        wr(8'h0C, 32'h0000_0000);
        wr(8'h08, 32'h0000_000A);
        wr(8'h04, 32'h0000_0000);
        wr(8'h00, 32'h0000_0000);
        wr(8'h10, 32'h0000_0003);
        idle(10);
        peek(8'h00, d); check("irq_mtime10", d, 32'h0000_000A);
        check("irq_not_yet", {31'd0, timer_interrupt}, 32'd0);
        peek(8'h14, d); check("irq_status", d, 32'h0000_0001);
        idle(1);
        check("irq_rise", {31'd0, timer_interrupt}, 32'd1);
        wr(8'h08, 32'h0000_0064);
        check("irq_hold", {31'd0, timer_interrupt}, 32'd1);
        idle(1);
        check("irq_fall", {31'd0, timer_interrupt}, 32'd0);

        // write wins over a simultaneous tick
        wr(8'h00, 32'h0000_0020);
        peek(8'h00, d); check("wwin_lo", d, 32'h0000_0020);
        peek(8'h04, d); check("wwin_hi", d, 32'h0000_0000);

        // decode: unmapped, misaligned, out-of-window
        wr(8'h10, 32'h0000_0000);
        peek_raw(BASE + 32'h1C, d, h);
        check("unmap_rdata", d, 32'd0); check("unmap_hit", {31'd0, h}, 32'd1);
        peek_raw(BASE + 32'h02, d, h);
        check("misal_rdata", d, 32'd0); check("misal_hit", {31'd0, h}, 32'd1);
        peek_raw(32'h0000_1000, d, h);
        check("oow_rdata", d, 32'd0); check("oow_hit", {31'd0, h}, 32'd0);
        addr = BASE;
        #1;
        check("nord_rdata", rdata, 32'd0);
        addr = 32'd0;
        wr_raw(BASE + 32'h1C, 32'h0000_DEAD);
        wr_raw(BASE + 32'h02, 32'h0000_1234);
        wr_raw(BASE + 32'h14, 32'hFFFF_FFFF);
        wr_raw(32'h0000_0010, 32'h0000_0303);
        wr_raw(32'h0000_0000, 32'h0000_5555);
        peek(8'h00, d); check("dec_lo", d, 32'h0000_0021);
        peek(8'h04, d); check("dec_hi", d, 32'h0000_0000);
        peek(8'h10, d); check("dec_ctrl", d, 32'h0000_0000);
        peek(8'h08, d); check("dec_cmp_lo", d, 32'h0000_0064);

        // reset in the middle of a prescaled run with a pending interrupt
        wr(8'h10, 32'h0000_0503);
        wr(8'h04, 32'h0000_0007);
        rd(8'h00, d); check("pre_lo", d, 32'h0000_0021);
        wr(8'h08, 32'h0000_0000);
        idle(1);
        check("pre_irq", {31'd0, timer_interrupt}, 32'd1);
        peek(8'h18, d); check("pre_snap", d, 32'h0000_0007);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        peek(8'h00, d); check("mid_lo", d, 32'h0000_0000);
        peek(8'h04, d); check("mid_hi", d, 32'h0000_0000);
        peek(8'h08, d); check("mid_cmp_lo", d, 32'hFFFF_FFFF);
        peek(8'h0C, d); check("mid_cmp_hi", d, 32'hFFFF_FFFF);
        peek(8'h10, d); check("mid_ctrl", d, 32'h0000_0001);
        peek(8'h18, d); check("mid_snap", d, 32'h0000_0000);
        check("mid_irq", {31'd0, timer_interrupt}, 32'd0);
        idle(1);
        peek(8'h00, d); check("mid_presc", d, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
